// File: rtl/bcd_conv_arbiter_if.sv
// Requester and converter signals for the shared BCD converter arbiter.
// The arbiter is the slave side; producers and the converter form the master side.
interface bcd_conv_arbiter_if #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned BIN_W = 12,
  parameter int unsigned BCD_W = 16
);
  logic [N_REQ-1:0]       req;
  logic [N_REQ*BIN_W-1:0] bin_in;
  logic [N_REQ-1:0]       ack;
  logic [BCD_W-1:0]       bcd_out;
  logic                   err;
  logic                   busy;
  logic                   conv_en;
  logic [BIN_W-1:0]       conv_bin;
  logic [BCD_W-1:0]       conv_bcd;
  logic                   conv_rdy;

  modport slave (
    input  req, bin_in, conv_bcd, conv_rdy,
    output ack, bcd_out, err, busy, conv_en, conv_bin
  );

  modport master (
    output req, bin_in, conv_bcd, conv_rdy,
    input  ack, bcd_out, err, busy, conv_en, conv_bin
  );
endinterface

// File: rtl/bcd_conv_arbiter.sv
// Round-robin arbiter sequencing one shared binary-to-BCD converter among N_REQ requesters,
// with a conversion timeout and a post-reset drain of any conversion still in flight.
module bcd_conv_arbiter #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned BIN_W   = 12,
  parameter int unsigned BCD_W   = 16,
  parameter int unsigned TIMEOUT = 100
) (
  input  logic               clk,
  input  logic               rst,
  bcd_conv_arbiter_if.slave  bus
);

  localparam int unsigned IdxW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {StDrain, StIdle, StLaunch, StWait, StDeliver} state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] ptr_q, ptr_d;
  logic [IdxW-1:0] grant_q, grant_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [BIN_W-1:0] bin_q, bin_d;
  logic [BCD_W-1:0] bcd_q, bcd_d;
  logic            err_q, err_d;

  logic            pick_vld;
  logic [IdxW-1:0] pick_idx;
  logic [IdxW-1:0] cand;

  // First pending requester after the last one served, wrapping modulo N_REQ.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      cand = IdxW'((32'(ptr_q) + k) % N_REQ);
      if (!pick_vld && bus.req[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StDrain;
      ptr_q   <= IdxW'(N_REQ - 1);
      grant_q <= '0;
      cnt_q   <= '0;
      bin_q   <= '0;
      bcd_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    err_d   = err_q;
    unique case (state_q)
      // The converter has no reset; a result arriving here belongs to an aborted request.
      StDrain: begin
        if (bus.conv_rdy || (cnt_q == CntW'(TIMEOUT - 1))) begin
          cnt_d   = '0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StIdle: begin
        if (pick_vld) begin
          grant_d = pick_idx;
          bin_d   = bus.bin_in[pick_idx*BIN_W +: BIN_W];
          state_d = StLaunch;
        end
      end
      StLaunch: begin
        cnt_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        cnt_d = cnt_q + 1'b1;
        if (bus.conv_rdy) begin
          bcd_d   = bus.conv_bcd;
          state_d = StDeliver;
        end else if (cnt_d == CntW'(TIMEOUT - 1)) begin
          bcd_d   = '1;
          err_d   = 1'b1;
          state_d = StDeliver;
        end
      end
      StDeliver: begin
        ptr_d   = grant_q;
        err_d   = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StDrain;
    endcase
  end

  always_comb begin
    bus.ack      = '0;
    bus.err      = 1'b0;
    bus.conv_en  = 1'b0;
    bus.busy     = (state_q != StIdle);
    bus.conv_bin = bin_q;
    bus.bcd_out  = bcd_q;
    unique case (state_q)
      StLaunch:  bus.conv_en = 1'b1;
      StDeliver: begin
        bus.ack[grant_q] = 1'b1;
        bus.err          = err_q;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/bcd_conv_arbiter.md
Name: bcd_conv_arbiter

Overview:
- Shares one 12-bit binary-to-BCD converter among N_REQ requesters using round-robin arbitration.
- Sequences the converter: latches the winner's operand, pulses the converter start, waits for its ready pulse, and returns the BCD result with a one-cycle ack.
- Adds a timeout and a post-reset drain so a stuck or mid-flight converter cannot deliver a wrong result.
- Sits between the display/UART producers and the single shared converter instance.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- BIN_W, 12, binary operand width
- BCD_W, 16, BCD result width (4 digits)
- TIMEOUT, 100, max WAIT cycles before abort (nominal conversion latency is 63)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- req  in  N_REQ  level request per requester
- bin_in  in  N_REQ*BIN_W  operands; requester i uses bits [i*BIN_W +: BIN_W]
- ack  out  N_REQ  one-cycle pulse to the served requester; bcd_out is valid in that cycle
- bcd_out  out  BCD_W  result register, shared by all requesters
- err  out  1  one-cycle pulse together with ack when the conversion timed out
- busy  out  1  high in every state except IDLE
- conv_en  out  1  converter start, one-cycle pulse
- conv_bin  out  BIN_W  converter operand, held stable from LAUNCH through WAIT
- conv_bcd  in  BCD_W  converter result
- conv_rdy  in  1  converter done pulse

Behaviour:
- Reset: rst is sampled only on the clk edge.
  - Outputs on reset: ack=0, err=0, conv_en=0, conv_bin=0, bcd_out=0, busy=1.
  - Round-robin pointer is set to N_REQ-1, so requester 0 has first priority.
  - State goes to DRAIN, whether or not a conversion was in progress.
- States:
  - DRAIN: the converter has no reset and may still be running. Count cycles; go to IDLE on conv_rdy or after TIMEOUT cycles, whichever comes first. conv_rdy is discarded.
  - IDLE: if any req bit is high, grant the first set bit searching upward from pointer+1 and wrapping modulo N_REQ. Latch the granted index, and copy that requester's bin_in slice into conv_bin. Go to LAUNCH. If no req is high, stay in IDLE.
  - LAUNCH: conv_en=1 for exactly this cycle. Clear the cycle counter. Go to WAIT.
  - WAIT: conv_en=0 and the counter increments.
    - On conv_rdy: register conv_bcd into bcd_out and go to DELIVER.
    - If the counter reaches TIMEOUT-1 without conv_rdy: load bcd_out with all ones, set the error flag, and go to DELIVER.
  - DELIVER: ack[grant]=1 for one cycle, with err=flag. Set pointer to grant, clear the flag, and go to IDLE.
- Converter contract:
  - conv_en must not be reasserted until at least 2 cycles after conv_rdy. The DELIVER→IDLE→LAUNCH path guarantees 3.
  - conv_bin must not change while the converter is running.
- conv_rdy seen in IDLE or LAUNCH is ignored (stale).
- Request rules:
  - Operands are sampled only at grant. Later changes to bin_in do not affect the conversion in flight.
  - A requester that keeps req high after its ack is treated as making a new request. It is re-arbitrated and will lose to any other pending requester.
  - A req dropped before grant is never served. A req dropped after grant is still served and acked.
- Throughput: one conversion per grant. Minimum request-to-ack time is 1 (IDLE) + 1 (LAUNCH) + converter latency + 1 (DELIVER).
- Reset at any point aborts the current conversion with no ack, then passes through DRAIN.

Test Plan:
- Single request: req[0]=1, bin_in slice 0 = 12'd4095 → one conv_en pulse, conv_bin=12'h FFF, then ack[0] pulse with bcd_out=16'h4095 and err=0. Repeat with 0 → 16'h0000 and with 12'd1234 → 16'h1234.
- Contention: req=4'b0101 held high, operands 12'd7 and 12'd999 → ack[0] with 16'h0007, then ack[2] with 16'h0999, then ack[0] again. Never two acks in a row to the same index while the other is pending.
- Pointer wrap: after ack[3], assert req=4'b1001 → requester 0 is served before requester 3.
- Timeout: converter stub never asserts conv_rdy → ack pulse exactly TIMEOUT cycles after LAUNCH, err=1, bcd_out=16'hFFFF. The next request then completes normally.
- Reset mid-WAIT: assert rst 20 cycles after LAUNCH, with the stub asserting conv_rdy 43 cycles later → no ack, and stays in DRAIN until that conv_rdy. The following request returns its own result, not the stale one.
- Operand change: change bin_in slice 0 from 12'd12 to 12'd34 one cycle after grant → ack[0] with 16'h0012.
